// File: rtl/bf16_normalize_pack_pkg.sv
// rtl/bf16_normalize_pack_pkg.sv - shared widths, state encoding and special encodings for the bf16 packer
package bf16_normalize_pack_pkg;

  localparam int DATA_WIDTH   = 16;
  localparam int EXP_WIDTH    = 8;
  localparam int FRAC_WIDTH   = 7;
  localparam int MANT_WIDTH   = 16;
  localparam int IN_EXP_WIDTH = EXP_WIDTH + 2;
  // One extra bit so normalization shifts and the rounding carry never wrap
  localparam int XEXP_WIDTH   = EXP_WIDTH + 3;
  localparam int EXP_MAX      = 255;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  typedef logic signed [XEXP_WIDTH-1:0] xexp_t;

  function automatic logic [DATA_WIDTH-1:0] zero_word(input logic sign);
    return {sign, {(DATA_WIDTH-1){1'b0}}};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] inf_word(input logic sign);
    return {sign, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
  endfunction

endpackage

// File: rtl/bf16_round_rne.sv
// rtl/bf16_round_rne.sv - round-to-nearest-even of a normalized mantissa to the packed fraction width
module bf16_round_rne
  import bf16_normalize_pack_pkg::*;
(
  input  logic [MANT_WIDTH-2:0] mant_low,
  input  xexp_t                 exp_in,
  output logic [FRAC_WIDTH-1:0] frac,
  output xexp_t                 exp_out
);

  // The hidden bit is always 1 here, so only the bits below it are needed
  localparam int GUARD = MANT_WIDTH - FRAC_WIDTH - 2;

  logic [FRAC_WIDTH-1:0] keep;
  logic                  guard;
  logic                  sticky;
  logic                  round_up;
  logic                  carry;

  // Guard/sticky RNE; an all-ones fraction rounding up wraps to 1.0 and bumps the exponent
  always_comb begin
    keep     = mant_low[MANT_WIDTH-2 -: FRAC_WIDTH];
    guard    = mant_low[GUARD];
    sticky   = |mant_low[GUARD-1:0];
    round_up = guard & (sticky | keep[0]);
    carry    = round_up & (&keep);
    frac     = keep + {{(FRAC_WIDTH-1){1'b0}}, round_up};
    exp_out  = carry ? exp_in + xexp_t'(1) : exp_in;
  end

endmodule

// File: rtl/bf16_normalize_pack.sv
// rtl/bf16_normalize_pack.sv - iterative normalize, RNE round and pack into bfloat16 with handshakes
module bf16_normalize_pack
  import bf16_normalize_pack_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [IN_EXP_WIDTH-1:0] in_exp,
  input  logic [MANT_WIDTH-1:0]   in_mant,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_zero,
  output logic                    out_overflow
);

  state_t                  state_q, state_d;
  logic                    sign_q, sign_d;
  xexp_t                   exp_q, exp_d;
  logic [MANT_WIDTH-1:0]   mant_q, mant_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_zero_q, out_zero_d;
  logic                    out_overflow_q, out_overflow_d;

  logic [FRAC_WIDTH-1:0]   rnd_frac;
  xexp_t                   rnd_exp;

  bf16_round_rne u_round (
    .mant_low (mant_q[MANT_WIDTH-2:0]),
    .exp_in   (exp_q),
    .frac     (rnd_frac),
    .exp_out  (rnd_exp)
  );

  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_zero     = out_zero_q;
  assign out_overflow = out_overflow_q;

  // Next-state and datapath: capture, shift one bit per cycle, then range-check and pack
  always_comb begin
    state_d        = state_q;
    sign_d         = sign_q;
    exp_d          = exp_q;
    mant_d         = mant_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_zero_d     = out_zero_q;
    out_overflow_d = out_overflow_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d = in_sign;
          exp_d  = {in_exp[IN_EXP_WIDTH-1], in_exp};
          mant_d = in_mant;
          if (in_mant == '0) begin
            out_data_d     = zero_word(in_sign);
            out_zero_d     = 1'b1;
            out_overflow_d = 1'b0;
            out_valid_d    = 1'b1;
            state_d        = S_OUT;
          end else begin
            state_d = S_NORM;
          end
        end
      end
      S_NORM: begin
        if (mant_q[MANT_WIDTH-1]) begin
          state_d = S_ROUND;
        end else begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - xexp_t'(1);
        end
      end
      S_ROUND: begin
        if (rnd_exp <= xexp_t'(0)) begin
          out_data_d     = zero_word(sign_q);
          out_zero_d     = 1'b1;
          out_overflow_d = 1'b0;
        end else if (rnd_exp >= xexp_t'(EXP_MAX)) begin
          out_data_d     = inf_word(sign_q);
          out_zero_d     = 1'b0;
          out_overflow_d = 1'b1;
        end else begin
          out_data_d     = {sign_q, rnd_exp[EXP_WIDTH-1:0], rnd_frac};
          out_zero_d     = 1'b0;
          out_overflow_d = 1'b0;
        end
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset discards any in-flight result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      sign_q         <= 1'b0;
      exp_q          <= '0;
      mant_q         <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_zero_q     <= 1'b0;
      out_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sign_q         <= sign_d;
      exp_q          <= exp_d;
      mant_q         <= mant_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_zero_q     <= out_zero_d;
      out_overflow_q <= out_overflow_d;
    end
  end

endmodule

// File: tb/tb_bf16_normalize_pack.sv
// tb/tb_bf16_normalize_pack.sv - directed self-checking bench for bf16_normalize_pack
module tb_bf16_normalize_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [15:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_zero;
  logic        out_overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic        s;
    logic [9:0]  e;
    logic [15:0] m;
    logic [15:0] d;
    logic        z;
    logic        o;
    int          lat;
  } vec_t;

  always #5 clk = ~clk;

  bf16_normalize_pack dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_mant      (in_mant),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_zero     (out_zero),
    .out_overflow (out_overflow)
  );

  // Drives one operation, measures latency (accept edge = cycle 0), captures the result, then completes the handshake
  task automatic run_op(input logic s, input logic [9:0] e, input logic [15:0] m,
                        output int lat, output logic [15:0] d, output logic z, output logic o,
                        output logic post_v, output logic post_r);
    @(negedge clk);
    in_sign = s; in_exp = e; in_mant = m; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    d = out_data; z = out_zero; o = out_overflow;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    post_v = out_valid; post_r = in_ready;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_sign = 1'b1; in_exp = 10'd127; in_mant = 16'h8000; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
    checks++; if (out_zero !== 1'b0 || out_overflow !== 1'b0) begin errors++; $display("FAIL reset_flags: got z=%b o=%b want 0 0", out_zero, out_overflow); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL reset_release: got valid=%b ready=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_zero();
    int lat; logic [15:0] d; logic z, o, pv, pr;
    run_op(1'b1, 10'h155, 16'h0000, lat, d, z, o, pv, pr);
    checks++; if (lat !== 1) begin errors++; $display("FAIL zero_latency: got %0d want 1", lat); end
    checks++; if (d !== 16'h8000) begin errors++; $display("FAIL zero_data: got %h want 8000", d); end
    checks++; if (z !== 1'b1 || o !== 1'b0) begin errors++; $display("FAIL zero_flags: got z=%b o=%b want 1 0", z, o); end
    checks++; if (pv !== 1'b0 || pr !== 1'b1) begin errors++; $display("FAIL zero_handshake: got valid=%b ready=%b want 0 1", pv, pr); end
  endtask

  task automatic test_datapath();
    vec_t tbl[13];
    int lat; logic [15:0] d; logic z, o, pv, pr;
    tbl = '{
      '{"norm_one",     1'b0, 10'd127, 16'h8000, 16'h3F80, 1'b0, 1'b0, 3},
      '{"norm_shift15", 1'b0, 10'd142, 16'h0001, 16'h3F80, 1'b0, 1'b0, 18},
      '{"norm_neg3",    1'b1, 10'd128, 16'hC000, 16'hC040, 1'b0, 1'b0, 3},
      '{"norm_minexp",  1'b0, 10'd1,   16'h8000, 16'h0080, 1'b0, 1'b0, 3},
      '{"rne_tie_even", 1'b0, 10'd127, 16'h8080, 16'h3F80, 1'b0, 1'b0, 3},
      '{"rne_tie_odd",  1'b0, 10'd127, 16'h8180, 16'h3F82, 1'b0, 1'b0, 3},
      '{"rne_carry",    1'b0, 10'd127, 16'hFF80, 16'h4000, 1'b0, 1'b0, 3},
      '{"rne_sticky",   1'b0, 10'd127, 16'h8081, 16'h3F81, 1'b0, 1'b0, 3},
      '{"ovf_exp255",   1'b0, 10'd255, 16'h8000, 16'h7F80, 1'b0, 1'b1, 3},
      '{"ovf_carry",    1'b0, 10'd254, 16'hFF80, 16'h7F80, 1'b0, 1'b1, 3},
      '{"unf_exp0",     1'b0, 10'd0,   16'h8000, 16'h0000, 1'b1, 1'b0, 3},
      '{"unf_shift",    1'b1, 10'd7,   16'h0100, 16'h8000, 1'b1, 1'b0, 10},
      '{"unf_negexp",   1'b0, 10'h3F0, 16'h8000, 16'h0000, 1'b1, 1'b0, 3}
    };
    foreach (tbl[i]) begin
      run_op(tbl[i].s, tbl[i].e, tbl[i].m, lat, d, z, o, pv, pr);
      checks++; if (lat !== tbl[i].lat) begin errors++; $display("FAIL %s_latency: got %0d want %0d", tbl[i].name, lat, tbl[i].lat); end
      checks++; if (d !== tbl[i].d) begin errors++; $display("FAIL %s_data: got %h want %h", tbl[i].name, d, tbl[i].d); end
      checks++; if (z !== tbl[i].z || o !== tbl[i].o) begin errors++; $display("FAIL %s_flags: got z=%b o=%b want %b %b", tbl[i].name, z, o, tbl[i].z, tbl[i].o); end
      checks++; if (pv !== 1'b0 || pr !== 1'b1) begin errors++; $display("FAIL %s_handshake: got valid=%b ready=%b want 0 1", tbl[i].name, pv, pr); end
    end
  endtask

  task automatic test_backpressure();
    bit seen = 0;
    @(negedge clk);
    in_sign = 1'b0; in_exp = 10'd127; in_mant = 16'h8180; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_valid_timeout: got valid=%b want 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h3F82 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got valid=%b data=%h ready=%b want 1 3f82 0", i, out_valid, out_data, in_ready);
      end
      in_sign = 1'b1; in_mant = 16'h0000; in_valid = (i == 1);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b want 0 1", out_valid, in_ready); end
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h3F82 || out_zero !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_capture: got valid=%b data=%h zero=%b want 0 3f82 0", out_valid, out_data, out_zero);
    end
  endtask

  task automatic test_reset_mid_norm();
    int lat; logic [15:0] d; logic z, o, pv, pr;
    @(negedge clk);
    in_sign = 1'b0; in_exp = 10'd142; in_mant = 16'h0001; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midnorm_busy: got ready=%b want 0", in_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midnorm_reset: got valid=%b ready=%b want 0 1", out_valid, in_ready); end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b0) begin
        checks++; errors++;
        $display("FAIL midnorm_ghost: got valid=%b want 0", out_valid);
        break;
      end
    end
    run_op(1'b0, 10'd127, 16'h8000, lat, d, z, o, pv, pr);
    checks++; if (lat !== 3) begin errors++; $display("FAIL post_reset_latency: got %0d want 3", lat); end
    checks++; if (d !== 16'h3F80) begin errors++; $display("FAIL post_reset_data: got %h want 3f80", d); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero();
    test_datapath();
    test_backpressure();
    test_reset_mid_norm();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
